serial_pattern_tx: RTL and testbench

SERIAL_PATTERN_TX -- requirements
Module: serial_pattern_tx

---
 rtl/serial_pattern_tx.sv | 142 ++++++++++++++
 tb/tb_serial_pattern_tx.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx: one-hot FSM serializer, MSB first, with Busy/Done.
// Define FSML_TX_PARITY_EN to append an even-parity bit (PAR state).
module serial_pattern_tx #(
  parameter int WIDTH = 8
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic [WIDTH-1:0]         Data,
  input  logic [$clog2(WIDTH):0]   Len,
  output logic                     Dout,
  output logic                     Busy,
  output logic                     Done,
  output logic [3:0]               State
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    SHIFT = 4'b0010,
    PAR   = 4'b0100,
    DONE  = 4'b1000
  } state_t;

  // Plain vectors so an illegal (non one-hot) code can be held and decoded.
  logic [3:0]       state_q;
  logic [3:0]       state_d;
  logic [WIDTH-1:0] sreg_q;
  logic [CW-1:0]    cnt_q;
  logic [CW-1:0]    eff_len;
  logic             load;
  logic             shift;

`ifdef FSML_TX_PARITY_EN
  logic             par_q;
`endif

  // Zero or oversize lengths select the full pattern width.
  always_comb begin
    eff_len = Len;
    if (Len == '0 || Len > CW'(WIDTH)) begin
      eff_len = CW'(WIDTH);
    end
  end

  // State register.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; any illegal code falls back to IDLE.
  always_comb begin
    state_d = IDLE;
    load    = 1'b0;
    shift   = 1'b0;
    case (state_q)
      IDLE: begin
        state_d = IDLE;
        if (Start) begin
          state_d = SHIFT;
          load    = 1'b1;
        end
      end
      SHIFT: begin
        shift   = 1'b1;
        state_d = SHIFT;
        if (cnt_q <= CW'(1)) begin
`ifdef FSML_TX_PARITY_EN
          state_d = PAR;
`else
          state_d = DONE;
`endif
        end
      end
      PAR: begin
`ifdef FSML_TX_PARITY_EN
        state_d = DONE;
`else
        state_d = IDLE;
`endif
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shift register and bit counter; only loaded on acceptance.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (load) begin
      sreg_q <= Data;
      cnt_q  <= eff_len;
    end else if (shift) begin
      sreg_q <= {sreg_q[WIDTH-2:0], 1'b0};
      cnt_q  <= cnt_q - CW'(1);
    end
  end

`ifdef FSML_TX_PARITY_EN
  // Running XOR of every bit that has left the shifter.
  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      par_q <= 1'b0;
    end else if (load) begin
      par_q <= 1'b0;
    end else if (shift) begin
      par_q <= par_q ^ sreg_q[WIDTH-1];
    end
  end
`endif

  // Outputs decode exact state codes, so illegal codes give all zeros.
  always_comb begin
    Dout = 1'b0;
    Busy = 1'b0;
    Done = 1'b0;
    if (state_q == SHIFT) begin
      Dout = sreg_q[WIDTH-1];
      Busy = 1'b1;
    end
`ifdef FSML_TX_PARITY_EN
    if (state_q == PAR) begin
      Dout = par_q;
      Busy = 1'b1;
    end
    State = state_q;
`else
    State = {state_q[3], 1'b0, state_q[1:0]};
`endif
    if (state_q == DONE) begin
      Done = 1'b1;
    end
  end

endmodule

// File: tb/tb_serial_pattern_tx.sv
// tb_serial_pattern_tx: scoreboard bench for serial_pattern_tx.
// Stimulus pushes expected bits/Done; a negedge monitor pops and compares.
module tb_serial_pattern_tx;

  logic       Clock;
  logic       Reset;
  logic       Start;
  logic [7:0] Data;
  logic [3:0] Len;
  logic       Dout;
  logic       Busy;
  logic       Done;
  logic [3:0] State;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit is_done;
    bit val;
  } exp_t;

  exp_t q[$];

  serial_pattern_tx #(.WIDTH(8)) dut (
    .Clock(Clock),
    .Reset(Reset),
    .Start(Start),
    .Data(Data),
    .Len(Len),
    .Dout(Dout),
    .Busy(Busy),
    .Done(Done),
    .State(State)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic check(input string name, input logic [3:0] act,
                       input logic [3:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push_xfer(input logic [15:0] bits, input int n,
                           input bit par, input bit with_done);
    exp_t e;
    for (int i = n - 1; i >= 0; i--) begin
      e.is_done = 1'b0;
      e.val     = bits[i];
      q.push_back(e);
    end
    if (with_done) begin
`ifdef FSML_TX_PARITY_EN
      e.is_done = 1'b0;
      e.val     = par;
      q.push_back(e);
`endif
      e.is_done = 1'b1;
      e.val     = 1'b0;
      q.push_back(e);
    end
  endtask

  task automatic wait_done(input string name);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge Clock);
      if (Done) got = 1'b1;
    end
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: no Done within 40 cycles", name);
    end
  endtask

  task automatic send(input string name, input logic [7:0] d,
                      input logic [3:0] l, input logic [15:0] bits,
                      input int n, input bit par);
    @(negedge Clock);
    Data  = d;
    Len   = l;
    Start = 1'b1;
    push_xfer(bits, n, par, 1'b1);
    @(posedge Clock);
    #1 Start = 1'b0;
    wait_done(name);
  endtask

  // Monitor: every active output cycle consumes one expected entry.
  always @(negedge Clock) begin
    if (Reset) begin
      if (Busy || Done) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_out: busy=%0b done=%0b dout=%0b",
                   Busy, Done, Dout);
        end else begin
          exp_t e;
          bit ok;
          e = q.pop_front();
          if (e.is_done) ok = Done && !Busy && !Dout;
          else ok = Busy && !Done && (Dout == e.val);
          if (!ok) begin
            errors++;
            $display("FAIL sb_%s: busy=%0b done=%0b dout=%0b exp=%0b",
                     e.is_done ? "done" : "bit", Busy, Done, Dout, e.val);
          end
        end
      end else begin
        checks++;
        if (Dout !== 1'b0) begin
          errors++;
          $display("FAIL idle_dout: got %0b expected 0", Dout);
        end
      end
    end
  end

  initial begin
    Reset = 1'b0;
    Start = 1'b0;
    Data  = 8'h00;
    Len   = 4'd0;
    #10;
    check("rst_state", State, 4'b0001);
    check("rst_busy", {3'b0, Busy}, 4'd0);
    check("rst_done", {3'b0, Done}, 4'd0);
    check("rst_dout", {3'b0, Dout}, 4'd0);
    #5 Reset = 1'b1;

    send("b2_len0", 8'hB2, 4'd0, 16'b10110010, 8, 1'b0);
    send("e0_len3", 8'hE0, 4'd3, 16'b111, 3, 1'b1);
    send("a0_len3", 8'hA0, 4'd3, 16'b101, 3, 1'b0);
    send("3c_len10", 8'h3C, 4'd10, 16'b00111100, 8, 1'b0);
    send("c8_len5", 8'hC8, 4'd5, 16'b11001, 5, 1'b1);

    // Data/Len change after acceptance must not matter.
    @(negedge Clock);
    Data  = 8'hF0;
    Len   = 4'd4;
    Start = 1'b1;
    push_xfer(16'b1111, 4, 1'b0, 1'b1);
    @(posedge Clock);
    #1 Start = 1'b0;
    @(negedge Clock);
    Data = 8'h0F;
    Len  = 4'd1;
    wait_done("data_change");

    // Start held high: three transfers, one IDLE cycle between each.
    @(negedge Clock);
    Data  = 8'hFF;
    Len   = 4'd2;
    Start = 1'b1;
    for (int k = 0; k < 3; k++) push_xfer(16'b11, 2, 1'b0, 1'b1);
    for (int k = 0; k < 3; k++) begin
      wait_done("held_start");
      @(negedge Clock);
      check("held_idle_state", State, 4'b0001);
      check("held_idle_busy", {3'b0, Busy}, 4'd0);
      if (k == 2) Start = 1'b0;
    end

    // Asynchronous reset after three bits of 0x55.
    @(negedge Clock);
    Data  = 8'h55;
    Len   = 4'd0;
    Start = 1'b1;
    push_xfer(16'b010, 3, 1'b0, 1'b0);
    @(posedge Clock);
    #1 Start = 1'b0;
    repeat (3) @(negedge Clock);
    #2 Reset = 1'b0;
    #1;
    check("mid_rst_state", State, 4'b0001);
    check("mid_rst_busy", {3'b0, Busy}, 4'd0);
    check("mid_rst_dout", {3'b0, Dout}, 4'd0);
    check("mid_rst_done", {3'b0, Done}, 4'd0);
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b1;
    check("mid_rst_q", 4'(q.size()), 4'd0);

    // Illegal state code recovers to IDLE on the next edge.
    @(negedge Clock);
    force dut.state_q = 4'b0110;
    #1;
    check("bad_busy", {3'b0, Busy}, 4'd0);
    check("bad_done", {3'b0, Done}, 4'd0);
    check("bad_dout", {3'b0, Dout}, 4'd0);
    release dut.state_q;
    @(posedge Clock);
    #1;
    check("bad_next_state", State, 4'b0001);
    check("bad_next_dout", {3'b0, Dout}, 4'd0);
    send("after_bad", 8'hC8, 4'd5, 16'b11001, 5, 1'b1);

    repeat (3) @(negedge Clock);
    check("sb_empty", 4'(q.size()), 4'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
